// File: rtl/riscv_definitions_pkg.sv
// riscv_definitions: shared type definitions for the phanes RV32I core.
//   alu_ops_t  - ALU operation code consumed by alu
//   op_a_sel_t - source select for ALU operand A (rs1 / pc / zero)
//   op_b_sel_t - source select for ALU operand B (rs2 / immediate)
package riscv_definitions;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_SLL  = 4'd2,
        ALU_SLT  = 4'd3,
        ALU_SLTU = 4'd4,
        ALU_XOR  = 4'd5,
        ALU_SRL  = 4'd6,
        ALU_SRA  = 4'd7,
        ALU_OR   = 4'd8,
        ALU_AND  = 4'd9
    } alu_ops_t;

    typedef enum logic [1:0] {
        OPA_RS1  = 2'd0,
        OPA_PC   = 2'd1,
        OPA_ZERO = 2'd2
    } op_a_sel_t;

    typedef enum logic {
        OPB_RS2 = 1'b0,
        OPB_IMM = 1'b1
    } op_b_sel_t;

endpackage

// File: rtl/operand_fwd_mux.sv
// operand_fwd_mux: resolves one register operand against in-flight producers.
// Priority: MEM stage result, then WB stage result, then the stored register
// data. Register x0 always reads as zero regardless of any producer.
//   rs_addr / rs_data          - registered source index and its stored data
//   mem_fwd_* / wb_fwd_*       - producer valid, destination and result
//   fwd_data                   - resolved operand value
module operand_fwd_mux #(
    parameter int XLEN       = 32,
    parameter int REG_ADDR_W = 5
) (
    input  logic [REG_ADDR_W-1:0] rs_addr,
    input  logic [XLEN-1:0]       rs_data,
    input  logic                  mem_fwd_valid,
    input  logic [REG_ADDR_W-1:0] mem_fwd_rd,
    input  logic [XLEN-1:0]       mem_fwd_data,
    input  logic                  wb_fwd_valid,
    input  logic [REG_ADDR_W-1:0] wb_fwd_rd,
    input  logic [XLEN-1:0]       wb_fwd_data,
    output logic [XLEN-1:0]       fwd_data
);

    logic rs_is_zero;
    logic mem_hit;
    logic wb_hit;

    always_comb begin
        rs_is_zero = (rs_addr == '0);
        mem_hit    = mem_fwd_valid && (mem_fwd_rd == rs_addr) && !rs_is_zero;
        wb_hit     = wb_fwd_valid && (wb_fwd_rd == rs_addr) && !rs_is_zero;
        fwd_data   = rs_data;
        if (rs_is_zero) begin
            fwd_data = '0;
        end else if (mem_hit) begin
            fwd_data = mem_fwd_data;
        end else if (wb_hit) begin
            fwd_data = wb_fwd_data;
        end
    end

endmodule

// File: rtl/id_ex_stage.sv
// id_ex_stage: decode-to-execute pipeline register for the phanes RV32I core.
// Holds one decoded instruction, forwards MEM/WB results into its register
// operands, and presents operand_a / operand_b / alu_op to the ALU.
//   in_valid/in_ready + id_*        - upstream decode handshake and payload
//   flush                           - drop held and incoming instruction
//   mem_fwd_* / wb_fwd_*            - forwarding sources
//   ex_valid/ex_ready + outputs     - downstream execute handshake and payload
//   stall_cycles                    - saturating count of back-pressured cycles
//
// Handshake: a transfer happens on a rising edge where valid && ready. The
// upstream side may offer at any time; in_ready is high whenever the single
// entry is empty or is being consumed in the same cycle. ex_valid stays high
// and the payload stays stable until ex_ready is seen. flush overrides both.
module id_ex_stage
    import riscv_definitions::*;
#(
    parameter int XLEN       = 32,
    parameter int REG_ADDR_W = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [XLEN-1:0]       id_pc,
    input  logic [REG_ADDR_W-1:0] id_rs1_addr,
    input  logic [REG_ADDR_W-1:0] id_rs2_addr,
    input  logic [REG_ADDR_W-1:0] id_rd_addr,
    input  logic [XLEN-1:0]       id_rs1_data,
    input  logic [XLEN-1:0]       id_rs2_data,
    input  logic [XLEN-1:0]       id_imm,
    input  alu_ops_t              id_alu_op,
    input  op_a_sel_t             id_op_a_sel,
    input  op_b_sel_t             id_op_b_sel,
    input  logic                  id_reg_write,
    input  logic                  flush,
    input  logic                  mem_fwd_valid,
    input  logic [REG_ADDR_W-1:0] mem_fwd_rd,
    input  logic [XLEN-1:0]       mem_fwd_data,
    input  logic                  wb_fwd_valid,
    input  logic [REG_ADDR_W-1:0] wb_fwd_rd,
    input  logic [XLEN-1:0]       wb_fwd_data,
    output logic                  ex_valid,
    input  logic                  ex_ready,
    output logic [XLEN-1:0]       operand_a,
    output logic [XLEN-1:0]       operand_b,
    output alu_ops_t              alu_op,
    output logic [XLEN-1:0]       ex_pc,
    output logic [REG_ADDR_W-1:0] ex_rd_addr,
    output logic                  ex_reg_write,
    output logic [31:0]           stall_cycles
);

    logic                  valid_q,       valid_d;
    logic [XLEN-1:0]       pc_q,          pc_d;
    logic [REG_ADDR_W-1:0] rs1_addr_q,    rs1_addr_d;
    logic [REG_ADDR_W-1:0] rs2_addr_q,    rs2_addr_d;
    logic [REG_ADDR_W-1:0] rd_addr_q,     rd_addr_d;
    logic [XLEN-1:0]       rs1_data_q,    rs1_data_d;
    logic [XLEN-1:0]       rs2_data_q,    rs2_data_d;
    logic [XLEN-1:0]       imm_q,         imm_d;
    alu_ops_t              alu_op_q,      alu_op_d;
    op_a_sel_t             op_a_sel_q,    op_a_sel_d;
    op_b_sel_t             op_b_sel_q,    op_b_sel_d;
    logic                  reg_write_q,   reg_write_d;
    logic [31:0]           stall_cycles_q, stall_cycles_d;

    logic            capture;
    logic            held;
    logic [XLEN-1:0] rs1_fwd;
    logic [XLEN-1:0] rs2_fwd;

    operand_fwd_mux #(.XLEN(XLEN), .REG_ADDR_W(REG_ADDR_W)) u_fwd_rs1 (
        .rs_addr      (rs1_addr_q),
        .rs_data      (rs1_data_q),
        .mem_fwd_valid(mem_fwd_valid),
        .mem_fwd_rd   (mem_fwd_rd),
        .mem_fwd_data (mem_fwd_data),
        .wb_fwd_valid (wb_fwd_valid),
        .wb_fwd_rd    (wb_fwd_rd),
        .wb_fwd_data  (wb_fwd_data),
        .fwd_data     (rs1_fwd)
    );

    operand_fwd_mux #(.XLEN(XLEN), .REG_ADDR_W(REG_ADDR_W)) u_fwd_rs2 (
        .rs_addr      (rs2_addr_q),
        .rs_data      (rs2_data_q),
        .mem_fwd_valid(mem_fwd_valid),
        .mem_fwd_rd   (mem_fwd_rd),
        .mem_fwd_data (mem_fwd_data),
        .wb_fwd_valid (wb_fwd_valid),
        .wb_fwd_rd    (wb_fwd_rd),
        .wb_fwd_data  (wb_fwd_data),
        .fwd_data     (rs2_fwd)
    );

    always_comb begin
        in_ready = !valid_q || ex_ready;
        capture  = in_valid && in_ready && !flush;
        held     = valid_q && !ex_ready;

        valid_d        = valid_q;
        pc_d           = pc_q;
        rs1_addr_d     = rs1_addr_q;
        rs2_addr_d     = rs2_addr_q;
        rd_addr_d      = rd_addr_q;
        rs1_data_d     = rs1_data_q;
        rs2_data_d     = rs2_data_q;
        imm_d          = imm_q;
        alu_op_d       = alu_op_q;
        op_a_sel_d     = op_a_sel_q;
        op_b_sel_d     = op_b_sel_q;
        reg_write_d    = reg_write_q;
        stall_cycles_d = stall_cycles_q;

        if (flush) begin
            valid_d = 1'b0;
        end else if (capture) begin
            valid_d = 1'b1;
        end else if (ex_ready) begin
            valid_d = 1'b0;
        end

        if (capture) begin
            pc_d        = id_pc;
            rs1_addr_d  = id_rs1_addr;
            rs2_addr_d  = id_rs2_addr;
            rd_addr_d   = id_rd_addr;
            rs1_data_d  = id_rs1_data;
            rs2_data_d  = id_rs2_data;
            imm_d       = id_imm;
            alu_op_d    = id_alu_op;
            op_a_sel_d  = id_op_a_sel;
            op_b_sel_d  = id_op_b_sel;
            reg_write_d = id_reg_write;
        end else if (held) begin
            // A producer may retire while we wait; latch its result so the
            // operand stays correct after the forward source disappears.
            rs1_data_d = rs1_fwd;
            rs2_data_d = rs2_fwd;
        end

        if (held && (stall_cycles_q != 32'hFFFF_FFFF)) begin
            stall_cycles_d = stall_cycles_q + 32'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q        <= 1'b0;
            pc_q           <= '0;
            rs1_addr_q     <= '0;
            rs2_addr_q     <= '0;
            rd_addr_q      <= '0;
            rs1_data_q     <= '0;
            rs2_data_q     <= '0;
            imm_q          <= '0;
            alu_op_q       <= ALU_ADD;
            op_a_sel_q     <= OPA_RS1;
            op_b_sel_q     <= OPB_RS2;
            reg_write_q    <= 1'b0;
            stall_cycles_q <= '0;
        end else begin
            valid_q        <= valid_d;
            pc_q           <= pc_d;
            rs1_addr_q     <= rs1_addr_d;
            rs2_addr_q     <= rs2_addr_d;
            rd_addr_q      <= rd_addr_d;
            rs1_data_q     <= rs1_data_d;
            rs2_data_q     <= rs2_data_d;
            imm_q          <= imm_d;
            alu_op_q       <= alu_op_d;
            op_a_sel_q     <= op_a_sel_d;
            op_b_sel_q     <= op_b_sel_d;
            reg_write_q    <= reg_write_d;
            stall_cycles_q <= stall_cycles_d;
        end
    end

    always_comb begin
        operand_a = '0;
        case (op_a_sel_q)
            OPA_RS1: operand_a = rs1_fwd;
            OPA_PC:  operand_a = pc_q;
            default: operand_a = '0;
        endcase
        operand_b = (op_b_sel_q == OPB_IMM) ? imm_q : rs2_fwd;
    end

    assign ex_valid     = valid_q;
    assign alu_op       = alu_op_q;
    assign ex_pc        = pc_q;
    assign ex_rd_addr   = rd_addr_q;
    assign ex_reg_write = reg_write_q && valid_q;
    assign stall_cycles = stall_cycles_q;

endmodule

// File: tb/tb_id_ex_stage.sv
module tb_id_ex_stage;
    import riscv_definitions::*;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] id_pc;
    logic [4:0]  id_rs1_addr, id_rs2_addr, id_rd_addr;
    logic [31:0] id_rs1_data, id_rs2_data, id_imm;
    alu_ops_t    id_alu_op;
    op_a_sel_t   id_op_a_sel;
    op_b_sel_t   id_op_b_sel;
    logic        id_reg_write;
    logic        flush;
    logic        mem_fwd_valid, wb_fwd_valid;
    logic [4:0]  mem_fwd_rd, wb_fwd_rd;
    logic [31:0] mem_fwd_data, wb_fwd_data;
    logic        ex_valid;
    logic        ex_ready;
    logic [31:0] operand_a, operand_b;
    alu_ops_t    alu_op;
    logic [31:0] ex_pc;
    logic [4:0]  ex_rd_addr;
    logic        ex_reg_write;
    logic [31:0] stall_cycles;

    int errors = 0;
    int checks = 0;

    // Reference model: one optional pending instruction plus a stall count.
    logic [31:0] exp_q[$];   // PCs of accepted, not yet retired instructions
    logic        m_valid;
    logic [31:0] m_pc, m_rs1_data, m_rs2_data, m_imm;
    logic [4:0]  m_rs1, m_rs2, m_rd;
    alu_ops_t    m_op;
    op_a_sel_t   m_asel;
    op_b_sel_t   m_bsel;
    logic        m_we;
    logic [31:0] m_stall;

    id_ex_stage dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .id_pc(id_pc),
        .id_rs1_addr(id_rs1_addr), .id_rs2_addr(id_rs2_addr), .id_rd_addr(id_rd_addr),
        .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data), .id_imm(id_imm),
        .id_alu_op(id_alu_op), .id_op_a_sel(id_op_a_sel), .id_op_b_sel(id_op_b_sel),
        .id_reg_write(id_reg_write), .flush(flush),
        .mem_fwd_valid(mem_fwd_valid), .mem_fwd_rd(mem_fwd_rd), .mem_fwd_data(mem_fwd_data),
        .wb_fwd_valid(wb_fwd_valid), .wb_fwd_rd(wb_fwd_rd), .wb_fwd_data(wb_fwd_data),
        .ex_valid(ex_valid), .ex_ready(ex_ready),
        .operand_a(operand_a), .operand_b(operand_b), .alu_op(alu_op),
        .ex_pc(ex_pc), .ex_rd_addr(ex_rd_addr), .ex_reg_write(ex_reg_write),
        .stall_cycles(stall_cycles)
    );

    // ---------------- clock / reset ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    // ---------------- reference model ----------------
    function automatic logic [31:0] ref_fwd(input logic [4:0] rs, input logic [31:0] stored);
        if (rs == 5'd0) return 32'd0;
        if (mem_fwd_valid && mem_fwd_rd == rs) return mem_fwd_data;
        if (wb_fwd_valid && wb_fwd_rd == rs) return wb_fwd_data;
        return stored;
    endfunction

    function automatic logic [31:0] ref_op_a();
        if (m_asel == OPA_RS1) return ref_fwd(m_rs1, m_rs1_data);
        if (m_asel == OPA_PC) return m_pc;
        return 32'd0;
    endfunction

    function automatic logic [31:0] ref_op_b();
        if (m_bsel == OPB_IMM) return m_imm;
        return ref_fwd(m_rs2, m_rs2_data);
    endfunction

    task automatic model_reset();
        exp_q.delete();
        m_valid = 0; m_pc = 0; m_rs1_data = 0; m_rs2_data = 0; m_imm = 0;
        m_rs1 = 0; m_rs2 = 0; m_rd = 0; m_op = ALU_ADD; m_asel = OPA_RS1;
        m_bsel = OPB_RS2; m_we = 0; m_stall = 0;
    endtask

    // Advance one clock: derive next model state from the inputs now applied,
    // then cross the rising edge and settle.
    task automatic step();
        logic stalled, accept;
        logic [31:0] new_a, new_b;
        stalled = m_valid && !ex_ready;
        accept  = in_valid && (!m_valid || ex_ready) && !flush;
        new_a   = ref_fwd(m_rs1, m_rs1_data);
        new_b   = ref_fwd(m_rs2, m_rs2_data);
        @(posedge clk);
        if (stalled && m_stall != 32'hFFFF_FFFF) m_stall = m_stall + 1;
        if (accept) begin
            m_pc = id_pc; m_rs1 = id_rs1_addr; m_rs2 = id_rs2_addr; m_rd = id_rd_addr;
            m_rs1_data = id_rs1_data; m_rs2_data = id_rs2_data; m_imm = id_imm;
            m_op = id_alu_op; m_asel = id_op_a_sel; m_bsel = id_op_b_sel; m_we = id_reg_write;
        end else if (stalled) begin
            m_rs1_data = new_a; m_rs2_data = new_b;
        end
        if (flush) begin
            exp_q.delete();
        end else if (accept) begin
            exp_q.delete();
            exp_q.push_back(id_pc);
        end else if (ex_ready) begin
            exp_q.delete();
        end
        m_valid = (exp_q.size() != 0);
        #1;
    endtask

    // ---------------- driver tasks ----------------
    task automatic idle_inputs();
        in_valid = 0; id_pc = 0; id_rs1_addr = 0; id_rs2_addr = 0; id_rd_addr = 0;
        id_rs1_data = 0; id_rs2_data = 0; id_imm = 0; id_alu_op = ALU_ADD;
        id_op_a_sel = OPA_RS1; id_op_b_sel = OPB_RS2; id_reg_write = 0; flush = 0;
        mem_fwd_valid = 0; mem_fwd_rd = 0; mem_fwd_data = 0;
        wb_fwd_valid = 0; wb_fwd_rd = 0; wb_fwd_data = 0; ex_ready = 1;
    endtask

    task automatic drive_instr(input logic [31:0] pc, input logic [4:0] rs1, input logic [4:0] rs2,
                               input logic [4:0] rd, input logic [31:0] d1, input logic [31:0] d2,
                               input logic [31:0] imm, input alu_ops_t op, input op_a_sel_t asel,
                               input op_b_sel_t bsel, input logic we);
        in_valid = 1; id_pc = pc; id_rs1_addr = rs1; id_rs2_addr = rs2; id_rd_addr = rd;
        id_rs1_data = d1; id_rs2_data = d2; id_imm = imm; id_alu_op = op;
        id_op_a_sel = asel; id_op_b_sel = bsel; id_reg_write = we;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1;
        @(posedge clk);
        #1;
        rst = 0;
        model_reset();
        #1;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        do_reset();
        checks++; if (ex_valid !== 1'b0) begin errors++; $display("FAIL reset_ex_valid: got %0b want 0", ex_valid); end
        checks++; if (operand_a !== 32'd0 || operand_b !== 32'd0) begin errors++; $display("FAIL reset_operands: got a=%0h b=%0h want 0/0", operand_a, operand_b); end
        checks++; if (alu_op !== ALU_ADD) begin errors++; $display("FAIL reset_alu_op: got %0d want %0d", alu_op, ALU_ADD); end
        checks++; if (stall_cycles !== 32'd0 || ex_rd_addr !== 5'd0 || ex_reg_write !== 1'b0) begin errors++; $display("FAIL reset_misc: got stall=%0d rd=%0d we=%0b want 0/0/0", stall_cycles, ex_rd_addr, ex_reg_write); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %0b want 1", in_ready); end
    endtask

    task automatic test_imm_operand();
        do_reset();
        drive_instr(32'h100, 5'd3, 5'd0, 5'd4, 32'd10, 32'd0, 32'd15, ALU_ADD, OPA_RS1, OPB_IMM, 1'b1);
        step();
        in_valid = 0;
        #1;
        checks++; if (ex_valid !== 1'b1) begin errors++; $display("FAIL imm_valid: got %0b want 1", ex_valid); end
        checks++; if (operand_a !== 32'd10 || operand_b !== 32'd15) begin errors++; $display("FAIL imm_operands: got a=%0d b=%0d want 10/15", operand_a, operand_b); end
        checks++; if (alu_op !== ALU_ADD || ex_pc !== 32'h100 || ex_rd_addr !== 5'd4 || ex_reg_write !== 1'b1) begin errors++; $display("FAIL imm_fields: got op=%0d pc=%0h rd=%0d we=%0b want 0/100/4/1", alu_op, ex_pc, ex_rd_addr, ex_reg_write); end
        step();
        checks++; if (ex_valid !== 1'b0) begin errors++; $display("FAIL imm_retire: got %0b want 0", ex_valid); end
    endtask

    task automatic test_forward_priority();
        do_reset();
        drive_instr(32'h200, 5'd5, 5'd6, 5'd1, 32'd1, 32'd9, 32'd0, ALU_SUB, OPA_RS1, OPB_RS2, 1'b1);
        step();
        in_valid = 0; ex_ready = 0;
        wb_fwd_valid = 1; wb_fwd_rd = 5'd5; wb_fwd_data = 32'd2;
        mem_fwd_valid = 1; mem_fwd_rd = 5'd5; mem_fwd_data = 32'd3;
        #1;
        checks++; if (operand_a !== 32'd3) begin errors++; $display("FAIL fwd_mem: got %0d want 3", operand_a); end
        checks++; if (operand_b !== 32'd9) begin errors++; $display("FAIL fwd_other_operand: got %0d want 9", operand_b); end
        mem_fwd_valid = 0;
        #1;
        checks++; if (operand_a !== 32'd2) begin errors++; $display("FAIL fwd_wb: got %0d want 2", operand_a); end
        wb_fwd_valid = 0;
        #1;
        checks++; if (operand_a !== 32'd1) begin errors++; $display("FAIL fwd_stored: got %0d want 1", operand_a); end
        ex_ready = 1;
        step();
    endtask

    task automatic test_x0_guard();
        do_reset();
        drive_instr(32'h300, 5'd0, 5'd0, 5'd2, 32'd7, 32'd7, 32'd0, ALU_OR, OPA_RS1, OPB_RS2, 1'b1);
        step();
        in_valid = 0; ex_ready = 0;
        mem_fwd_valid = 1; mem_fwd_rd = 5'd0; mem_fwd_data = 32'hDEADBEEF;
        wb_fwd_valid = 1; wb_fwd_rd = 5'd0; wb_fwd_data = 32'h12345678;
        #1;
        checks++; if (operand_b !== 32'd0 || operand_a !== 32'd0) begin errors++; $display("FAIL x0_guard: got a=%0h b=%0h want 0/0", operand_a, operand_b); end
        idle_inputs();
        step();
    endtask

    task automatic test_stall_refresh();
        do_reset();
        drive_instr(32'h400, 5'd1, 5'd7, 5'd8, 32'd4, 32'd0, 32'd0, ALU_XOR, OPA_PC, OPB_RS2, 1'b1);
        step();
        in_valid = 0; ex_ready = 0;
        wb_fwd_valid = 1; wb_fwd_rd = 5'd7; wb_fwd_data = 32'h55;
        #1;
        checks++; if (operand_b !== 32'h55 || operand_a !== 32'h400) begin errors++; $display("FAIL stall_first: got a=%0h b=%0h want 400/55", operand_a, operand_b); end
        step();
        wb_fwd_valid = 0;
        for (int i = 2; i <= 3; i++) begin
            #1;
            checks++; if (operand_b !== 32'h55 || in_ready !== 1'b0) begin errors++; $display("FAIL stall_hold_%0d: got b=%0h in_ready=%0b want 55/0", i, operand_b, in_ready); end
            step();
        end
        checks++; if (stall_cycles !== 32'd3) begin errors++; $display("FAIL stall_count: got %0d want 3", stall_cycles); end
        ex_ready = 1;
        step();
        checks++; if (ex_valid !== 1'b0 || stall_cycles !== 32'd3) begin errors++; $display("FAIL stall_release: got valid=%0b count=%0d want 0/3", ex_valid, stall_cycles); end
    endtask

    task automatic test_flush();
        do_reset();
        drive_instr(32'h500, 5'd1, 5'd2, 5'd3, 32'd1, 32'd2, 32'd0, ALU_AND, OPA_RS1, OPB_RS2, 1'b1);
        step();
        drive_instr(32'h504, 5'd4, 5'd5, 5'd6, 32'd3, 32'd4, 32'd0, ALU_SLL, OPA_RS1, OPB_RS2, 1'b1);
        flush = 1;
        #1;
        checks++; if (ex_valid !== 1'b1 || in_ready !== 1'b1) begin errors++; $display("FAIL flush_pre: got valid=%0b in_ready=%0b want 1/1", ex_valid, in_ready); end
        step();
        flush = 0; in_valid = 0;
        #1;
        checks++; if (ex_valid !== 1'b0 || ex_reg_write !== 1'b0) begin errors++; $display("FAIL flush_drop: got valid=%0b we=%0b want 0/0", ex_valid, ex_reg_write); end
        checks++; if (ex_pc === 32'h504) begin errors++; $display("FAIL flush_no_capture: got pc=%0h want not 504", ex_pc); end
        // Flush during a stall: held entry drops, counter stops after flush cycle.
        drive_instr(32'h600, 5'd1, 5'd2, 5'd3, 32'd1, 32'd2, 32'd0, ALU_ADD, OPA_RS1, OPB_RS2, 1'b1);
        step();
        in_valid = 0; ex_ready = 0; flush = 1;
        step();
        flush = 0;
        step();
        checks++; if (ex_valid !== 1'b0 || stall_cycles !== 32'd1) begin errors++; $display("FAIL flush_stall: got valid=%0b count=%0d want 0/1", ex_valid, stall_cycles); end
        ex_ready = 1;
    endtask

    task automatic test_async_reset();
        do_reset();
        drive_instr(32'h700, 5'd9, 5'd10, 5'd11, 32'h77, 32'h88, 32'd0, ALU_SRA, OPA_RS1, OPB_RS2, 1'b1);
        step();
        in_valid = 0; ex_ready = 0;
        step();
        checks++; if (ex_valid !== 1'b1 || stall_cycles !== 32'd1) begin errors++; $display("FAIL areset_pre: got valid=%0b count=%0d want 1/1", ex_valid, stall_cycles); end
        #2;
        rst = 1;
        #1;
        checks++; if (ex_valid !== 1'b0 || operand_a !== 32'd0 || operand_b !== 32'd0) begin errors++; $display("FAIL areset_clear: got valid=%0b a=%0h b=%0h want 0/0/0", ex_valid, operand_a, operand_b); end
        checks++; if (stall_cycles !== 32'd0 || alu_op !== ALU_ADD) begin errors++; $display("FAIL areset_state: got count=%0d op=%0d want 0/0", stall_cycles, alu_op); end
        rst = 0;
        model_reset();
        idle_inputs();
        step();
    endtask

    task automatic test_back_to_back();
        do_reset();
        for (int i = 0; i < 4; i++) begin
            drive_instr(32'h800 + 32'(i * 4), 5'd1, 5'd2, 5'(i + 1), 32'(i), 32'(i * 2), 32'd0,
                        ALU_ADD, OPA_RS1, OPB_RS2, 1'b1);
            step();
            checks++; if (ex_valid !== 1'b1 || ex_pc !== 32'h800 + 32'(i * 4) || operand_a !== 32'(i)) begin
                errors++; $display("FAIL b2b_%0d: got valid=%0b pc=%0h a=%0d want 1/%0h/%0d", i, ex_valid, ex_pc, operand_a, 32'h800 + 32'(i * 4), i);
            end
        end
        idle_inputs();
        step();
    endtask

    task automatic test_random();
        do_reset();
        for (int n = 0; n < 400; n++) begin
            in_valid     = ($urandom_range(0, 3) != 0);
            id_pc        = $urandom & 32'hFFFF_FFFC;
            id_rs1_addr  = 5'($urandom_range(0, 3));
            id_rs2_addr  = 5'($urandom_range(0, 3));
            id_rd_addr   = 5'($urandom_range(0, 31));
            id_rs1_data  = $urandom;
            id_rs2_data  = $urandom;
            id_imm       = $urandom;
            id_alu_op    = alu_ops_t'($urandom_range(0, 9));
            id_op_a_sel  = op_a_sel_t'($urandom_range(0, 2));
            id_op_b_sel  = op_b_sel_t'($urandom_range(0, 1));
            id_reg_write = 1'($urandom_range(0, 1));
            flush        = ($urandom_range(0, 15) == 0);
            ex_ready     = ($urandom_range(0, 2) != 0);
            mem_fwd_valid = 1'($urandom_range(0, 1));
            mem_fwd_rd    = 5'($urandom_range(0, 3));
            mem_fwd_data  = $urandom;
            wb_fwd_valid  = 1'($urandom_range(0, 1));
            wb_fwd_rd     = 5'($urandom_range(0, 3));
            wb_fwd_data   = $urandom;
            #1;
            checks++;
            if (ex_valid !== m_valid || in_ready !== (!m_valid || ex_ready) || stall_cycles !== m_stall) begin
                errors++;
                $display("FAIL rand_ctrl[%0d]: got valid=%0b in_ready=%0b count=%0d want %0b/%0b/%0d",
                         n, ex_valid, in_ready, stall_cycles, m_valid, (!m_valid || ex_ready), m_stall);
            end
            if (m_valid) begin
                checks++;
                if (operand_a !== ref_op_a() || operand_b !== ref_op_b() || alu_op !== m_op ||
                    ex_pc !== exp_q[0] || ex_rd_addr !== m_rd || ex_reg_write !== m_we) begin
                    errors++;
                    $display("FAIL rand_data[%0d]: got a=%0h b=%0h op=%0d pc=%0h rd=%0d we=%0b want %0h/%0h/%0d/%0h/%0d/%0b",
                             n, operand_a, operand_b, alu_op, ex_pc, ex_rd_addr, ex_reg_write,
                             ref_op_a(), ref_op_b(), m_op, exp_q[0], m_rd, m_we);
                end
            end
            step();
        end
        idle_inputs();
        step();
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        rst = 1;
        idle_inputs();
        model_reset();
        test_reset();
        test_imm_operand();
        test_forward_priority();
        test_x0_guard();
        test_stall_refresh();
        test_flush();
        test_async_reset();
        test_back_to_back();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
